// File: rtl/l2_line_arbiter.sv
// rtl/l2_line_arbiter.sv - I/D cache arbiter onto one 256-bit line port.
// Round-robin-ish with a starvation guard that bounds D-cache grant streaks while I waits.
module l2_line_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int LINE_W       = 256,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_read_i,
    input  logic [ADDR_W-1:0] i_address_i,
    output logic [LINE_W-1:0] i_line_o,
    output logic              i_resp_o,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_address_i,
    input  logic [LINE_W-1:0] d_line_i,
    output logic [LINE_W-1:0] d_line_o,
    output logic              d_resp_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic [LINE_W-1:0] mem_line_o,
    input  logic [LINE_W-1:0] mem_line_i,
    input  logic              mem_resp_i,
    output logic              busy_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_I_RD = 3'd1,
        S_D_RD = 3'd2,
        S_D_WR = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [3:0] LP_MAX = 4'(MAX_D_STREAK);

    state_t            r_state;
    state_t            w_next_state;
    logic              r_req_d;
    logic [3:0]        r_streak;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wline;
    logic [LINE_W-1:0] r_iline;
    logic [LINE_W-1:0] r_dline;

    logic w_d_pending;
    logic w_pick_i;
    logic w_grant_i;
    logic w_grant_d_rd;
    logic w_grant_d_wr;
    logic w_grant_d;

    assign w_d_pending = d_write_i | d_read_i;
    // I only beats a pending D request once D has used up its streak allowance.
    assign w_pick_i    = i_read_i & (~w_d_pending | (r_streak == LP_MAX));
    assign w_grant_d   = w_grant_d_rd | w_grant_d_wr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_i    = 1'b0;
        w_grant_d_rd = 1'b0;
        w_grant_d_wr = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_pick_i) begin
                    w_grant_i    = 1'b1;
                    w_next_state = S_I_RD;
                end else if (d_write_i) begin
                    w_grant_d_wr = 1'b1;
                    w_next_state = S_D_WR;
                end else if (d_read_i) begin
                    w_grant_d_rd = 1'b1;
                    w_next_state = S_D_RD;
                end
            end
            S_I_RD, S_D_RD, S_D_WR: begin
                if (mem_resp_i) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_streak <= 4'd0;
        end else if (r_state == S_IDLE) begin
            if (w_grant_i || !i_read_i) begin
                r_streak <= 4'd0;
            end else if (w_grant_d && (r_streak < LP_MAX)) begin
                r_streak <= r_streak + 4'd1;
            end
        end
    end

    // Address/data only load on a grant, so they are frozen for the whole transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req_d <= 1'b0;
            r_addr  <= '0;
            r_wline <= '0;
            r_iline <= '0;
            r_dline <= '0;
        end else begin
            if (w_grant_i) begin
                r_req_d <= 1'b0;
                r_addr  <= i_address_i;
            end else if (w_grant_d) begin
                r_req_d <= 1'b1;
                r_addr  <= d_address_i;
                if (w_grant_d_wr) begin
                    r_wline <= d_line_i;
                end
            end
            if (mem_resp_i && (r_state == S_I_RD)) begin
                r_iline <= mem_line_i;
            end
            if (mem_resp_i && (r_state == S_D_RD)) begin
                r_dline <= mem_line_i;
            end
        end
    end

    assign mem_read_o    = (r_state == S_I_RD) | (r_state == S_D_RD);
    assign mem_write_o   = (r_state == S_D_WR);
    assign mem_address_o = r_addr;
    assign mem_line_o    = r_wline;
    assign i_line_o      = r_iline;
    assign d_line_o      = r_dline;
    assign i_resp_o      = (r_state == S_DONE) & ~r_req_d;
    assign d_resp_o      = (r_state == S_DONE) & r_req_d;
    assign busy_o        = (r_state != S_IDLE);

endmodule

// File: tb/tb_l2_line_arbiter.sv
// tb/tb_l2_line_arbiter.sv - directed scoreboard bench for l2_line_arbiter.
module tb_l2_line_arbiter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         i_read_i;
    logic [31:0]  i_address_i;
    logic [255:0] i_line_o;
    logic         i_resp_o;
    logic         d_read_i;
    logic         d_write_i;
    logic [31:0]  d_address_i;
    logic [255:0] d_line_i;
    logic [255:0] d_line_o;
    logic         d_resp_o;
    logic         mem_read_o;
    logic         mem_write_o;
    logic [31:0]  mem_address_o;
    logic [255:0] mem_line_o;
    logic [255:0] mem_line_i;
    logic         mem_resp_i;
    logic         busy_o;

    always #5 clk = ~clk;

    l2_line_arbiter #(.ADDR_W(32), .LINE_W(256), .MAX_D_STREAK(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_read_i(i_read_i), .i_address_i(i_address_i), .i_line_o(i_line_o), .i_resp_o(i_resp_o),
        .d_read_i(d_read_i), .d_write_i(d_write_i), .d_address_i(d_address_i), .d_line_i(d_line_i),
        .d_line_o(d_line_o), .d_resp_o(d_resp_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .mem_address_o(mem_address_o),
        .mem_line_o(mem_line_o), .mem_line_i(mem_line_i), .mem_resp_i(mem_resp_i), .busy_o(busy_o)
    );

    typedef struct {
        logic         is_d;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wline;
    } txn_t;

    txn_t         sb[$];
    int           tests = 0;
    int           fails = 0;
    logic [255:0] exp_iline = '0;
    logic [255:0] exp_dline = '0;

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic checkw(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Serve one downstream transaction: match it to the scoreboard head, answer after
    // 'delay' cycles, then check the response pulse and the line registers.
    task automatic do_txn(input int delay, input logic [255:0] rdata, input logic [2:0] drop,
                          input bit toggle);
        txn_t t;
        int   waited = 0;
        while (!(mem_read_o || mem_write_o) && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check1("mem_req_seen", mem_read_o | mem_write_o, 1'b1);
        check1("sb_nonempty", sb.size() != 0, 1'b1);
        if (sb.size() == 0) return;
        t = sb.pop_front();
        check1("mem_write", mem_write_o, t.wr);
        check1("mem_read", mem_read_o, !t.wr);
        checkw("mem_addr", 256'(mem_address_o), 256'(t.addr));
        if (t.wr) checkw("mem_line", mem_line_o, t.wline);
        for (int k = 0; k < delay; k++) begin
            if (toggle) begin
                d_address_i = $urandom;
                d_line_i    = {8{$urandom}};
            end
            @(negedge clk);
            checkw("addr_stable", 256'(mem_address_o), 256'(t.addr));
            if (t.wr) checkw("line_stable", mem_line_o, t.wline);
        end
        mem_resp_i = 1'b1;
        mem_line_i = rdata;
        @(negedge clk);
        mem_resp_i = 1'b0;
        mem_line_i = ~rdata;
        if (!t.wr) begin
            if (t.is_d) exp_dline = rdata;
            else        exp_iline = rdata;
        end
        check1("i_resp_pulse", i_resp_o, !t.is_d);
        check1("d_resp_pulse", d_resp_o, t.is_d);
        checkw("i_line", i_line_o, exp_iline);
        checkw("d_line", d_line_o, exp_dline);
        check1("mem_read_drop", mem_read_o, 1'b0);
        check1("mem_write_drop", mem_write_o, 1'b0);
        if (drop[2]) i_read_i = 1'b0;
        if (drop[1]) d_read_i = 1'b0;
        if (drop[0]) d_write_i = 1'b0;
        @(negedge clk);
        check1("i_resp_one", i_resp_o, 1'b0);
        check1("d_resp_one", d_resp_o, 1'b0);
        check1("idle_busy", busy_o, 1'b0);
    endtask

    initial begin
        logic [255:0] rd;
        int           waited;

        reset_n     = 1'b0;
        i_read_i    = 1'b1;
        d_read_i    = 1'b1;
        d_write_i   = 1'b1;
        i_address_i = 32'hDEAD_0000;
        d_address_i = 32'hBEEF_0000;
        d_line_i    = {8{32'hFFFF_0000}};
        mem_line_i  = '0;
        mem_resp_i  = 1'b0;
        repeat (3) @(negedge clk);
        check1("rst_mem_read", mem_read_o, 1'b0);
        check1("rst_mem_write", mem_write_o, 1'b0);
        checkw("rst_mem_addr", 256'(mem_address_o), 256'd0);
        checkw("rst_mem_line", mem_line_o, 256'd0);
        checkw("rst_i_line", i_line_o, 256'd0);
        checkw("rst_d_line", d_line_o, 256'd0);
        check1("rst_i_resp", i_resp_o, 1'b0);
        check1("rst_d_resp", d_resp_o, 1'b0);
        check1("rst_busy", busy_o, 1'b0);

        // Release with only an I read pending: request visible one cycle later.
        d_read_i    = 1'b0;
        d_write_i   = 1'b0;
        i_address_i = 32'h0000_1000;
        sb.push_back('{is_d: 1'b0, wr: 1'b0, addr: 32'h0000_1000, wline: '0});
        reset_n     = 1'b1;
        @(negedge clk);
        check1("first_mem_read", mem_read_o, 1'b1);
        checkw("first_mem_addr", 256'(mem_address_o), 256'h1000);
        do_txn(3, {32{8'hA5}}, 3'b100, 1'b0);

        // Dirty miss: write-back first, then the refill read at the same address.
        @(negedge clk);
        d_address_i = 32'h0000_0040;
        d_line_i    = {8{32'h1234_5678}};
        d_write_i   = 1'b1;
        d_read_i    = 1'b1;
        sb.push_back('{is_d: 1'b1, wr: 1'b1, addr: 32'h40, wline: {8{32'h1234_5678}}});
        sb.push_back('{is_d: 1'b1, wr: 1'b0, addr: 32'h40, wline: '0});
        do_txn(1, {8{32'h0BAD_F00D}}, 3'b001, 1'b0);
        do_txn(1, {8{32'hC3C3_5A5A}}, 3'b010, 1'b0);

        // Starvation guard with both reads held high.
        repeat (2) @(negedge clk);
        i_address_i = 32'h0000_1000;
        d_address_i = 32'h0000_2000;
        i_read_i    = 1'b1;
        d_read_i    = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (k == 4 || k == 9) sb.push_back('{is_d: 1'b0, wr: 1'b0, addr: 32'h1000, wline: '0});
            else                  sb.push_back('{is_d: 1'b1, wr: 1'b0, addr: 32'h2000, wline: '0});
        end
        for (int k = 0; k < 10; k++) begin
            rd = {8{32'h0101_0101 * 32'(k) + 32'h11}};
            do_txn(1, rd, (k == 9) ? 3'b110 : 3'b000, 1'b0);
        end

        // Write-back with inputs churning and a slow memory.
        @(negedge clk);
        d_address_i = 32'h0000_0080;
        d_line_i    = {8{32'h5566_7788}};
        d_write_i   = 1'b1;
        sb.push_back('{is_d: 1'b1, wr: 1'b1, addr: 32'h80, wline: {8{32'h5566_7788}}});
        do_txn(10, {8{32'h7777_0000}}, 3'b001, 1'b1);

        // Spurious memory response while idle.
        repeat (2) @(negedge clk);
        mem_resp_i = 1'b1;
        mem_line_i = {8{32'hEEEE_EEEE}};
        @(negedge clk);
        mem_resp_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            check1("spur_i_resp", i_resp_o, 1'b0);
            check1("spur_d_resp", d_resp_o, 1'b0);
            check1("spur_busy", busy_o, 1'b0);
            @(negedge clk);
        end

        // Reset in the middle of a D read.
        d_address_i = 32'h0000_0300;
        d_read_i    = 1'b1;
        waited      = 0;
        while (!mem_read_o && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check1("midrst_read_seen", mem_read_o, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check1("midrst_read_drop", mem_read_o, 1'b0);
        check1("midrst_busy", busy_o, 1'b0);
        @(negedge clk);
        d_read_i   = 1'b0;
        reset_n    = 1'b1;
        mem_resp_i = 1'b1;
        @(negedge clk);
        mem_resp_i = 1'b0;
        exp_dline  = '0;
        for (int k = 0; k < 4; k++) begin
            check1("midrst_no_dresp", d_resp_o, 1'b0);
            check1("midrst_idle", busy_o, 1'b0);
            @(negedge clk);
        end
        checkw("midrst_d_line", d_line_o, exp_dline);
        checkw("sb_drained", 256'(sb.size()), 256'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
